// File: rtl/tile_pkg.sv
// Shared types and constants for the scrolling tile-lane address generator.
// Optional feature macro: TILE_SCROLL_BANNER_EN (half-resolution banner shown while idle).
package tile_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Default play-field geometry
    localparam int unsigned DEF_LANES    = 3;
    localparam int unsigned DEF_ROWS     = 5;
    localparam int unsigned DEF_TILE_W   = 96;
    localparam int unsigned DEF_TILE_H   = 96;
    localparam int unsigned DEF_X0       = 176;
    localparam int unsigned DEF_SCREEN_H = 480;
    localparam int unsigned DEF_ADDR_W   = 17;
    localparam int unsigned DEF_SPEED_W  = 3;

    // Banner window and its ROM placement
    localparam int unsigned BANNER_BASE = 18432;
    localparam int unsigned BANNER_X0   = 170;
    localparam int unsigned BANNER_Y0   = 140;
    localparam int unsigned BANNER_WIN_W = 300;
    localparam int unsigned BANNER_WIN_H = 200;
    localparam int unsigned BANNER_W    = 150;

endpackage

// File: rtl/tile_scroll_ctrl.sv
// Scroll FSM, frame-synchronous offset ring counter and row-entry pulse.
module tile_scroll_ctrl
    import tile_pkg::*;
#(
    parameter int unsigned ROWS    = DEF_ROWS,
    parameter int unsigned TILE_H  = DEF_TILE_H,
    parameter int unsigned SPEED_W = DEF_SPEED_W,
    parameter int unsigned OFF_W   = $clog2(DEF_ROWS * DEF_TILE_H),
    parameter int unsigned RW      = (DEF_ROWS > 1) ? $clog2(DEF_ROWS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               run,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed,
    output logic [OFF_W-1:0]   offset,
    output state_t             state,
    output logic               row_enter,
    output logic [RW-1:0]      row_idx
);

    localparam int unsigned RING = ROWS * TILE_H;
    localparam int unsigned SW   = OFF_W + 1;

    logic [SW-1:0]    sum;
    logic [OFF_W-1:0] next_off;
    logic [RW-1:0]    cur_row;
    logic [RW-1:0]    next_row;
    logic [RW-1:0]    enter_idx;

    // Row number of an offset via a constant compare chain
    function automatic logic [RW-1:0] row_of(input logic [OFF_W-1:0] off);
        logic [RW-1:0] r;
        r = '0;
        for (int unsigned i = 1; i < ROWS; i++) begin
            if (off >= OFF_W'(i * TILE_H)) r = RW'(i);
        end
        return r;
    endfunction

    // Advanced offset with ring wrap, and the row that newly enters the top band
    always_comb begin
        sum       = SW'(offset) + SW'(speed);
        next_off  = (sum >= SW'(RING)) ? OFF_W'(sum - SW'(RING)) : OFF_W'(sum);
        cur_row   = row_of(offset);
        next_row  = row_of(next_off);
        enter_idx = (next_row == '0) ? '0 : RW'(RW'(ROWS) - next_row);
    end

    // FSM, offset register and row-entry pulse; clear overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            offset    <= '0;
            row_enter <= 1'b0;
            row_idx   <= '0;
        end else begin
            row_enter <= 1'b0;
            if (clear) begin
                state  <= IDLE;
                offset <= '0;
            end else begin
                case (state)
                    IDLE:    if (run)  state <= SCROLL;
                    SCROLL:  if (!run) state <= HOLD;
                    HOLD:    if (run)  state <= SCROLL;
                    default: state <= IDLE;
                endcase
                if (state == IDLE) begin
                    offset <= '0;
                end else if (state == SCROLL && frame_tick) begin
                    offset <= next_off;
                    if (next_row != cur_row) begin
                        row_enter <= 1'b1;
                        row_idx   <= enter_idx;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tile_scroll_addr_gen.sv
// Scrolling tile-lane image-ROM address generator for the VGA play field.
// Optional feature macro: TILE_SCROLL_BANNER_EN (banner window replaces tiles while idle).
module tile_scroll_addr_gen
    import tile_pkg::*;
#(
    parameter int unsigned LANES    = DEF_LANES,
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned TILE_W   = DEF_TILE_W,
    parameter int unsigned TILE_H   = DEF_TILE_H,
    parameter int unsigned X0       = DEF_X0,
    parameter int unsigned SCREEN_H = DEF_SCREEN_H,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned SPEED_W  = DEF_SPEED_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   frame_tick,
    input  logic                                   run,
    input  logic                                   clear,
    input  logic [SPEED_W-1:0]                     speed,
    input  logic [9:0]                             h_cnt,
    input  logic [9:0]                             v_cnt,
    input  logic [ROWS*LANES-1:0]                  tile_kind,
    output logic [ADDR_W-1:0]                      pixel_addr,
    output logic                                   pixel_valid,
    output logic                                   row_enter,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_idx
);

    localparam int unsigned RING  = ROWS * TILE_H;
    localparam int unsigned OFF_W = $clog2(RING);
    localparam int unsigned AW    = ADDR_W + 1;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned KW    = ((ROWS * LANES) > 1) ? $clog2(ROWS * LANES) : 1;
    localparam int unsigned X1    = X0 + LANES * TILE_W;

    logic [OFF_W-1:0] offset;
    state_t           state;

    logic [AW-1:0] h, v, off, y, line, x, col, addr_c;
    logic [RW-1:0] r;
    logic [LW-1:0] l;
    logic [KW-1:0] kidx;
    logic          kind;
    logic          in_field;
    logic          valid_c;
`ifdef TILE_SCROLL_BANNER_EN
    logic [AW-1:0] bx, by;
    logic          in_banner;
`endif

    tile_scroll_ctrl #(
        .ROWS    (ROWS),
        .TILE_H  (TILE_H),
        .SPEED_W (SPEED_W),
        .OFF_W   (OFF_W),
        .RW      (RW)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .run        (run),
        .clear      (clear),
        .speed      (speed),
        .offset     (offset),
        .state      (state),
        .row_enter  (row_enter),
        .row_idx    (row_idx)
    );

    // Map the current pixel onto ring row/lane and the tile's ROM image
    always_comb begin
        h   = AW'(h_cnt);
        v   = AW'(v_cnt);
        off = (state == IDLE) ? '0 : AW'(offset);

        y = v + AW'(RING) - off;
        if (y >= AW'(RING)) y = y - AW'(RING);

        r    = '0;
        line = y;
        for (int unsigned i = 1; i < ROWS; i++) begin
            if (y >= AW'(i * TILE_H)) begin
                r    = RW'(i);
                line = y - AW'(i * TILE_H);
            end
        end

        x   = h - AW'(X0);
        l   = '0;
        col = x;
        for (int unsigned i = 1; i < LANES; i++) begin
            if (x >= AW'(i * TILE_W)) begin
                l   = LW'(i);
                col = x - AW'(i * TILE_W);
            end
        end

        kidx = KW'(KW'(r) * KW'(LANES) + KW'(l));
        kind = tile_kind[kidx];

        in_field = (v < AW'(SCREEN_H)) && (h >= AW'(X0)) && (h < AW'(X1));

        addr_c  = '0;
        valid_c = 1'b0;
        if (in_field) begin
            addr_c  = line * AW'(TILE_W) + col + (kind ? AW'(TILE_W * TILE_H) : '0);
            valid_c = 1'b1;
        end

`ifdef TILE_SCROLL_BANNER_EN
        bx = (h - AW'(BANNER_X0)) >> 1;
        by = (v - AW'(BANNER_Y0)) >> 1;
        in_banner = (h >= AW'(BANNER_X0)) && (h < AW'(BANNER_X0 + BANNER_WIN_W)) &&
                    (v >= AW'(BANNER_Y0)) && (v < AW'(BANNER_Y0 + BANNER_WIN_H));
        if (state == IDLE) begin
            addr_c  = '0;
            valid_c = 1'b0;
            if (in_banner) begin
                addr_c  = bx + by * AW'(BANNER_W) + AW'(BANNER_BASE);
                valid_c = 1'b1;
            end
        end
`endif
    end

    // One-cycle pixel pipeline stage feeding the ROM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_addr  <= '0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_addr  <= addr_c[ADDR_W-1:0];
            pixel_valid <= valid_c;
        end
    end

endmodule

// File: tb/tb_tile_scroll_addr_gen.sv
// Directed self-checking bench for tile_scroll_addr_gen (default geometry).
module tb_tile_scroll_addr_gen;
    import tile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        run;
    logic        clear;
    logic [2:0]  speed;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [14:0] tile_kind;
    logic [16:0] pixel_addr;
    logic        pixel_valid;
    logic        row_enter;
    logic [2:0]  row_idx;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic       tk_pulse;
    logic [2:0] tk_idx;

    tile_scroll_addr_gen dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .run         (run),
        .clear       (clear),
        .speed       (speed),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .tile_kind   (tile_kind),
        .pixel_addr  (pixel_addr),
        .pixel_valid (pixel_valid),
        .row_enter   (row_enter),
        .row_idx     (row_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    // One frame tick; starts and ends at a falling edge, captures the pulse
    task automatic do_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        tk_pulse = row_enter;
        tk_idx   = row_idx;
    endtask

    task automatic pix(input int hh, input int vv);
        h_cnt = 10'(hh);
        v_cnt = 10'(vv);
        @(negedge clk);
    endtask

    task automatic test_reset();
        total_cnt++;
        if (pixel_addr !== 17'd0) $display("FAIL reset_addr: got %0d want 0", pixel_addr);
        else pass_cnt++;
        total_cnt++;
        if (pixel_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", pixel_valid);
        else pass_cnt++;
        total_cnt++;
        if (row_enter !== 1'b0 || row_idx !== 3'd0)
            $display("FAIL reset_row: got enter=%0b idx=%0d want 0/0", row_enter, row_idx);
        else pass_cnt++;
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd0 || dut.u_ctrl.state !== IDLE)
            $display("FAIL reset_ctrl: got off=%0d st=%0d want 0/IDLE", dut.u_ctrl.offset, dut.u_ctrl.state);
        else pass_cnt++;
    endtask

    task automatic test_pixel_map();
        tile_kind = 15'b000_000_000_000_010;
        pix(272, 5);
        total_cnt++;
        if (pixel_addr !== 17'd9696 || pixel_valid !== 1'b1)
            $display("FAIL map_kind1: got %0d/%0b want 9696/1", pixel_addr, pixel_valid);
        else pass_cnt++;
        pix(100, 5);
        total_cnt++;
        if (pixel_addr !== 17'd0 || pixel_valid !== 1'b0)
            $display("FAIL map_left: got %0d/%0b want 0/0", pixel_addr, pixel_valid);
        else pass_cnt++;
        pix(463, 479);
        total_cnt++;
        if (pixel_addr !== 17'd9215 || pixel_valid !== 1'b1)
            $display("FAIL map_corner: got %0d/%0b want 9215/1", pixel_addr, pixel_valid);
        else pass_cnt++;
        pix(463, 480);
        total_cnt++;
        if (pixel_addr !== 17'd0 || pixel_valid !== 1'b0)
            $display("FAIL map_below: got %0d/%0b want 0/0", pixel_addr, pixel_valid);
        else pass_cnt++;
        pix(464, 0);
        total_cnt++;
        if (pixel_addr !== 17'd0 || pixel_valid !== 1'b0)
            $display("FAIL map_right: got %0d/%0b want 0/0", pixel_addr, pixel_valid);
        else pass_cnt++;
        pix(176, 0);
        total_cnt++;
        if (pixel_addr !== 17'd0 || pixel_valid !== 1'b1)
            $display("FAIL map_origin: got %0d/%0b want 0/1", pixel_addr, pixel_valid);
        else pass_cnt++;
    endtask

    task automatic test_banner();
        pix(172, 142);
        total_cnt++;
        if (pixel_addr !== 17'd18583 || pixel_valid !== 1'b1)
            $display("FAIL banner_addr: got %0d/%0b want 18583/1", pixel_addr, pixel_valid);
        else pass_cnt++;
        pix(100, 100);
        total_cnt++;
        if (pixel_addr !== 17'd0 || pixel_valid !== 1'b0)
            $display("FAIL banner_out: got %0d/%0b want 0/0", pixel_addr, pixel_valid);
        else pass_cnt++;
    endtask

    task automatic test_slow_scroll();
        int pulses;
        pulses = 0;
        run = 1'b1;
        @(negedge clk);
        speed = 3'd2;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            if (tk_pulse) pulses++;
        end
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd20) $display("FAIL slow_offset: got %0d want 20", dut.u_ctrl.offset);
        else pass_cnt++;
        total_cnt++;
        if (pulses !== 0) $display("FAIL slow_pulses: got %0d want 0", pulses);
        else pass_cnt++;
        // offset 20: v=5 -> y=465, row 4 line 81; h=378 -> lane 2 col 10; kind bit 14 set
        tile_kind = 15'b100_000_000_000_010;
        pix(378, 5);
        total_cnt++;
        if (pixel_addr !== 17'd17002 || pixel_valid !== 1'b1)
            $display("FAIL scroll_map: got %0d/%0b want 17002/1", pixel_addr, pixel_valid);
        else pass_cnt++;
    endtask

    task automatic test_row_enter();
        int pulses;
        pulses = 0;
        speed = 3'd7;
        for (int i = 0; i < 10; i++) begin
            do_tick();
            if (tk_pulse) pulses++;
        end
        speed = 3'd4;
        do_tick();
        if (tk_pulse) pulses++;
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd94 || pulses !== 0)
            $display("FAIL pre_enter: got off=%0d pulses=%0d want 94/0", dut.u_ctrl.offset, pulses);
        else pass_cnt++;
        do_tick();
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd98) $display("FAIL enter_offset: got %0d want 98", dut.u_ctrl.offset);
        else pass_cnt++;
        total_cnt++;
        if (tk_pulse !== 1'b1 || tk_idx !== 3'd4)
            $display("FAIL enter_pulse: got %0b/%0d want 1/4", tk_pulse, tk_idx);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (row_enter !== 1'b0) $display("FAIL enter_width: got %0b want 0", row_enter);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        speed = 3'd7;
        for (int i = 0; i < 54; i++) do_tick();
        speed = 3'd2;
        do_tick();
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd478 || tk_pulse !== 1'b0)
            $display("FAIL pre_wrap: got off=%0d pulse=%0b want 478/0", dut.u_ctrl.offset, tk_pulse);
        else pass_cnt++;
        speed = 3'd3;
        do_tick();
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd1) $display("FAIL wrap_offset: got %0d want 1", dut.u_ctrl.offset);
        else pass_cnt++;
        total_cnt++;
        if (tk_pulse !== 1'b1 || tk_idx !== 3'd0)
            $display("FAIL wrap_pulse: got %0b/%0d want 1/0", tk_pulse, tk_idx);
        else pass_cnt++;
    endtask

    task automatic test_speed_zero();
        speed = 3'd0;
        do_tick();
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd1 || tk_pulse !== 1'b0)
            $display("FAIL speed0: got off=%0d pulse=%0b want 1/0", dut.u_ctrl.offset, tk_pulse);
        else pass_cnt++;
    endtask

    task automatic test_hold_clear();
        speed = 3'd5;
        run   = 1'b0;
        do_tick();
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd6 || dut.u_ctrl.state !== HOLD)
            $display("FAIL fall_tick: got off=%0d st=%0d want 6/HOLD", dut.u_ctrl.offset, dut.u_ctrl.state);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) do_tick();
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd6) $display("FAIL hold_frozen: got %0d want 6", dut.u_ctrl.offset);
        else pass_cnt++;
        run = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (dut.u_ctrl.state !== SCROLL) $display("FAIL resume: got st=%0d want SCROLL", dut.u_ctrl.state);
        else pass_cnt++;
        clear = 1'b1;
        run   = 1'b0;
        do_tick();
        clear = 1'b0;
        total_cnt++;
        if (dut.u_ctrl.offset !== 9'd0 || dut.u_ctrl.state !== IDLE || tk_pulse !== 1'b0)
            $display("FAIL clear_tick: got off=%0d st=%0d pulse=%0b want 0/IDLE/0",
                     dut.u_ctrl.offset, dut.u_ctrl.state, tk_pulse);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        run = 1'b1;
        @(negedge clk);
        speed = 3'd3;
        do_tick();
        tile_kind = 15'b000_000_000_000_010;
        // offset 3: v=5 -> y=2, row 0 line 2; h=272 -> lane 1 col 0, kind 1
        pix(272, 5);
        total_cnt++;
        if (pixel_addr !== 17'd9408 || pixel_valid !== 1'b1)
            $display("FAIL pre_reset_map: got %0d/%0b want 9408/1", pixel_addr, pixel_valid);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if (pixel_addr !== 17'd0 || pixel_valid !== 1'b0 ||
            dut.u_ctrl.offset !== 9'd0 || dut.u_ctrl.state !== IDLE)
            $display("FAIL async_reset: got addr=%0d v=%0b off=%0d st=%0d want 0/0/0/IDLE",
                     pixel_addr, pixel_valid, dut.u_ctrl.offset, dut.u_ctrl.state);
        else pass_cnt++;
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        run        = 1'b0;
        clear      = 1'b0;
        speed      = 3'd0;
        h_cnt      = 10'd0;
        v_cnt      = 10'd0;
        tile_kind  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        test_reset();
`ifdef TILE_SCROLL_BANNER_EN
        test_banner();
`else
        test_pixel_map();
`endif
        test_slow_scroll();
        test_row_enter();
        test_wrap();
        test_speed_zero();
        test_hold_clear();
        test_reset_midframe();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
